// File: rtl/vcb_updown_mod_cntr.sv
// Reversible modulo counter: programmable terminal value, sync clamped load,
// wrap/saturate mode, sticky overflow flag and TC/CEO cascade outputs.
module vcb_updown_mod_cntr #(
    parameter int W       = 4,
    parameter bit SAT_DEF = 1'b0
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         ce,
    input  logic         up,
    input  logic         L,
    input  logic [W-1:0] di,
    input  logic [W-1:0] max_val,
    input  logic         sat,
    input  logic         ovf_clr,
    output logic [W-1:0] Q,
    output logic         TC,
    output logic         CEO,
    output logic         ovf
);

    logic         sat_q;
    logic [W-1:0] q_nxt;

    always_comb begin
        TC  = up ? (Q == max_val) : (Q == '0);
        CEO = ce & TC;
    end

    always_comb begin
        q_nxt = Q;
        if (L) begin
            q_nxt = (di > max_val) ? max_val : di;
        end else if (ce) begin
            // An out-of-range value (max_val lowered at runtime) snaps back in either direction
            if (Q > max_val)
                q_nxt = max_val;
            else if (up)
                q_nxt = (Q == max_val) ? (sat_q ? max_val : '0) : Q + W'(1);
            else
                q_nxt = (Q == '0) ? (sat_q ? '0 : max_val) : Q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            Q     <= '0;
            ovf   <= 1'b0;
            sat_q <= SAT_DEF;
        end else begin
            Q     <= q_nxt;
            sat_q <= sat;
            if (ce && !L && TC)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vcb_updown_mod_cntr.sv
// Bench for vcb_updown_mod_cntr: directed scenarios, randomized traffic checked
// against an arithmetic reference model, and a two-stage cascade.
module tb_vcb_updown_mod_cntr;

    logic       clk = 1'b0;
    logic       clr, ce, up, L, sat, ovf_clr;
    logic [3:0] di, max_val, Q;
    logic       TC, CEO, ovf;

    logic       cce;
    logic [3:0] q0, q1;
    logic       tc0, tc1, ceo0, ceo1, ovf0, ovf1;

    int total = 0;
    int bad   = 0;
    int mq    = 0;
    bit movf  = 1'b0;

    vcb_updown_mod_cntr #(.W(4), .SAT_DEF(1'b0)) dut (
        .clk(clk), .clr(clr), .ce(ce), .up(up), .L(L), .di(di), .max_val(max_val),
        .sat(sat), .ovf_clr(ovf_clr), .Q(Q), .TC(TC), .CEO(CEO), .ovf(ovf)
    );

    vcb_updown_mod_cntr #(.W(4), .SAT_DEF(1'b0)) c0 (
        .clk(clk), .clr(clr), .ce(cce), .up(1'b1), .L(1'b0), .di(4'd0), .max_val(4'd15),
        .sat(1'b0), .ovf_clr(1'b0), .Q(q0), .TC(tc0), .CEO(ceo0), .ovf(ovf0)
    );

    vcb_updown_mod_cntr #(.W(4), .SAT_DEF(1'b0)) c1 (
        .clk(clk), .clr(clr), .ce(ceo0), .up(1'b1), .L(1'b0), .di(4'd0), .max_val(4'd15),
        .sat(1'b0), .ovf_clr(1'b0), .Q(q1), .TC(tc1), .CEO(ceo1), .ovf(ovf1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_comb();
        bit term;
        term = up ? (mq == int'(max_val)) : (mq == 0);
        chk("tc", {31'd0, TC}, {31'd0, term});
        chk("ceo", {31'd0, CEO}, {31'd0, term & ce});
    endtask

    // Reference: in-range counting is arithmetic modulo (max_val+1) or a clamp to [0,max_val]
    task automatic tick();
        int mx = int'(max_val);
        int nq = mq;
        bit term;
        term = up ? (mq == mx) : (mq == 0);
        if (L)
            nq = (int'(di) > mx) ? mx : int'(di);
        else if (ce) begin
            if (mq > mx)
                nq = mx;
            else if (sat)
                nq = up ? ((mq + 1 > mx) ? mx : mq + 1) : ((mq == 0) ? 0 : mq - 1);
            else
                nq = up ? (mq + 1) % (mx + 1) : (mq + mx) % (mx + 1);
        end
        if (ce && !L && term)
            movf = 1'b1;
        else if (ovf_clr)
            movf = 1'b0;
        mq = nq;
        @(posedge clk);
        #1;
        chk("q", {28'd0, Q}, mq);
        chk("ovf", {31'd0, ovf}, {31'd0, movf});
        chk_comb();
    endtask

    task automatic idle();
        ce = 1'b0;
        L  = 1'b0;
        tick();
    endtask

    initial begin
        clr = 1'b1; ce = 1'b0; up = 1'b1; L = 1'b0; sat = 1'b0; ovf_clr = 1'b0;
        di = 4'd0; max_val = 4'd9; cce = 1'b0;

        // Reset state
        #12;
        chk("rst_q", {28'd0, Q}, 0);
        chk("rst_ovf", {31'd0, ovf}, 0);
        chk("rst_tc_up", {31'd0, TC}, 0);
        up = 1'b0;
        #1;
        chk("rst_tc_dn", {31'd0, TC}, 1);
        up = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;

        // Wrap up-count 0..9
        ce = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("t1_q", {28'd0, Q}, 2);
        chk("t1_ovf", {31'd0, ovf}, 1);

        // Down through zero
        up = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("t2_q", {28'd0, Q}, 8);

        // Saturate
        sat = 1'b1; max_val = 4'd5;
        idle();
        L = 1'b1; di = 4'd5;
        tick();
        L = 1'b0; ce = 1'b1; up = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("t3_hold", {28'd0, Q}, 5);
        up = 1'b0;
        tick(); tick();
        chk("t3_dn", {28'd0, Q}, 3);

        // Clamped load beats count
        sat = 1'b0; max_val = 4'd9;
        idle();
        L = 1'b1; ce = 1'b1; up = 1'b1; di = 4'd12;
        tick();
        chk("t4_clamp", {28'd0, Q}, 9);
        di = 4'd3;
        tick();
        chk("t4_load", {28'd0, Q}, 3);

        // Out of range, ovf_clr priority
        di = 4'd8;
        tick();
        L = 1'b0; max_val = 4'd4; up = 1'b0; ce = 1'b1;
        tick();
        chk("t5_snap", {28'd0, Q}, 4);
        ce = 1'b0; ovf_clr = 1'b1;
        tick();
        chk("t5_clr", {31'd0, ovf}, 0);
        ce = 1'b1; up = 1'b1;
        tick();
        chk("t5_race", {31'd0, ovf}, 1);
        ovf_clr = 1'b0;

        // max_val = 0
        max_val = 4'd0;
        L = 1'b1; di = 4'd7; ce = 1'b0;
        tick();
        L = 1'b0; ce = 1'b1; ovf_clr = 1'b1;
        tick(); tick();
        chk("mx0_q", {28'd0, Q}, 0);
        chk("mx0_ovf", {31'd0, ovf}, 1);
        ovf_clr = 1'b0; max_val = 4'd9;

        // Asynchronous clear between edges
        tick(); tick();
        #2 clr = 1'b1;
        #1;
        chk("aclr_q", {28'd0, Q}, 0);
        chk("aclr_ovf", {31'd0, ovf}, 0);
        mq = 0; movf = 1'b0;
        #3 clr = 1'b0;
        #1;
        tick();

        // Randomized traffic; sat only changes ahead of an idle edge
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                sat = 1'($urandom_range(0, 1));
                idle();
            end
            ce      = ($urandom % 4) != 0;
            up      = 1'($urandom);
            L       = ($urandom % 8) == 0;
            di      = 4'($urandom);
            ovf_clr = ($urandom % 8) == 0;
            if ($urandom % 12 == 0) max_val = 4'($urandom);
            tick();
        end

        // Two-stage cascade
        ce = 1'b0; L = 1'b0; ovf_clr = 1'b0;
        #2 clr = 1'b1;
        #2 clr = 1'b0;
        @(negedge clk);
        cce = 1'b1;
        for (int i = 0; i < 20; i++) @(posedge clk);
        #1;
        chk("casc_val", {24'd0, q1, q0}, 20);
        #2 clr = 1'b1;
        #1;
        chk("casc_clr", {24'd0, q1, q0}, 0);
        clr = 1'b0;
        cce = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
